// File: rtl/vga_pmod_driver.sv
// rtl/vga_pmod_driver.sv - VGA timing generator and TinyVGA PMOD output stage
// Optional mode 1/2 pattern generators are built only when VGA_PMOD_TESTPAT_EN is defined.
module vga_pmod_driver #(
    parameter int COLOR_W  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int LATENCY  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             mode_in,
    input  logic [3*COLOR_W-1:0]   rgb_in,
    output logic [9:0]             pix_x,
    output logic [9:0]             pix_y,
    output logic                   pix_valid,
    output logic                   frame_start,
    output logic                   line_start,
    output logic [7:0]             uo_out
);
    localparam int         H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic       INV     = ~SYNC_POL;
    localparam logic [7:0] IDLE    = SYNC_POL ? 8'h00 : 8'h11;

    // Syncs are carried as "active" flags and converted to pin polarity at the output register.
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       vld;
        logic       pat;
        logic [5:0] col;
    } pix_t;

    logic [9:0] h_q, h_d, v_q, v_d;
    logic [1:0] mode_q, mode_d, mode_now;
    logic       hs_act, vs_act;
    logic       pat_sel;
    logic [5:0] pat_col;
    logic [5:0] scene, col;
    logic [7:0] uo_q, uo_d;
    logic       unused_rgb;
    pix_t       cur, dly;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q    <= '0;
            v_q    <= '0;
            mode_q <= '0;
            uo_q   <= IDLE;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            mode_q <= mode_d;
            uo_q   <= uo_d;
        end
    end

    always_comb begin
        h_d = h_q + 10'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end
    end

    assign pix_x       = h_q;
    assign pix_y       = v_q;
    assign pix_valid   = (h_q < H_ACT) && (v_q < V_ACT);
    assign line_start  = (h_q == '0);
    assign frame_start = line_start && (v_q == '0);
    assign hs_act      = (h_q >= HS_BEG) && (h_q < HS_END);
    assign vs_act      = (v_q >= VS_BEG) && (v_q < VS_END);

    // The request is used directly on the frame_start pixel so the first pixel already has the new mode.
    assign mode_now = frame_start ? mode_in : mode_q;
    assign mode_d   = mode_now;

`ifdef VGA_PMOD_TESTPAT_EN
    logic [2:0] bar;
    assign bar = 3'({h_q, 3'b000} / 13'(H_ACTIVE));

    always_comb begin
        pat_sel = 1'b1;
        pat_col = '0;
        case (mode_now)
            2'd1:    pat_col = {{2{bar[2]}}, {2{bar[1]}}, {2{bar[0]}}};
            2'd2:    pat_col = {6{h_q[5] ^ v_q[5]}};
            2'd3:    pat_col = '0;
            default: pat_sel = 1'b0;
        endcase
    end
`else
    assign pat_sel = (mode_now == 2'd3);
    assign pat_col = '0;
`endif

    assign cur = {hs_act, vs_act, pix_valid, pat_sel, pat_col};

    generate
        if (LATENCY == 0) begin : g_nodly
            assign dly = cur;
        end else begin : g_dly
            pix_t pipe_q [LATENCY];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= cur;
                    for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign dly = pipe_q[LATENCY-1];
        end
    endgenerate

    generate
        if (COLOR_W == 1) begin : g_rep
            assign scene = {{2{rgb_in[2]}}, {2{rgb_in[1]}}, {2{rgb_in[0]}}};
        end else begin : g_top
            assign scene = {rgb_in[3*COLOR_W-1 -: 2], rgb_in[2*COLOR_W-1 -: 2], rgb_in[COLOR_W-1 -: 2]};
        end
    endgenerate
    assign unused_rgb = ^rgb_in;

    always_comb begin
        col = '0;
        if (dly.vld) col = dly.pat ? dly.col : scene;
        uo_d = {col[5], col[3], col[1], dly.vs ^ INV, col[4], col[2], col[0], dly.hs ^ INV};
    end

    assign uo_out = uo_q;
endmodule

// File: tb/tb_vga_pmod_driver.sv
// tb/tb_vga_pmod_driver.sv - scoreboard bench for vga_pmod_driver
// Two configurations share clock, reset and mode; a frame-level model predicts every output.
module tb_vga_pmod_driver;
    localparam int HA = 64, HF = 4, HS = 8, HB = 4, HT = HA + HF + HS + HB;
    localparam int VA = 48, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
    localparam int LA = 3, LB = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode_in = 2'd0;
    logic [5:0] rgb_a = '0;
    logic [2:0] rgb_b = '0;
    logic [9:0] px_a, py_a, px_b, py_b;
    logic       pv_a, fs_a, ls_a, pv_b, fs_b, ls_b;
    logic [7:0] uo_a, uo_b;

    int         n = 0;
    int         tests = 0;
    int         fails = 0;
    bit         sparse = 1'b0;
    logic [1:0] frame_mode = 2'd0;
    logic [22:0] pixq[$];
    logic [7:0]  outq_a[$];
    logic [7:0]  outq_b[$];
    logic [5:0]  hist_a[$];

    always #5 clk = ~clk;

    vga_pmod_driver #(
        .COLOR_W(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0), .LATENCY(LA)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .mode_in(mode_in), .rgb_in(rgb_a),
        .pix_x(px_a), .pix_y(py_a), .pix_valid(pv_a), .frame_start(fs_a),
        .line_start(ls_a), .uo_out(uo_a)
    );

    vga_pmod_driver #(
        .COLOR_W(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1), .LATENCY(LB)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .mode_in(mode_in), .rgb_in(rgb_b),
        .pix_x(px_b), .pix_y(py_b), .pix_valid(pv_b), .frame_start(fs_b),
        .line_start(ls_b), .uo_out(uo_b)
    );

    function automatic int chan(int rgb, int k, int cw);
        int val;
        val = (rgb >> (k * cw)) % (1 << cw);
        return (cw == 1) ? val * 3 : val >> (cw - 2);
    endfunction

    function automatic logic [7:0] model_uo(int h, int v, logic [1:0] mode, int rgb, int cw, bit pol);
        int r, g, b, m, bar, hl, vl;
        bit hs, vs;
        hs = (h >= HA + HF) && (h < HA + HF + HS);
        vs = (v >= VA + VF) && (v < VA + VF + VS);
        r = 0; g = 0; b = 0;
        m = int'(mode);
`ifndef VGA_PMOD_TESTPAT_EN
        if (m == 1 || m == 2) m = 0;
`endif
        if (h < HA && v < VA) begin
            case (m)
                0: begin r = chan(rgb, 2, cw); g = chan(rgb, 1, cw); b = chan(rgb, 0, cw); end
                1: begin bar = h * 8 / HA; r = (bar / 4) % 2 * 3; g = (bar / 2) % 2 * 3; b = bar % 2 * 3; end
                2: if (((h / 32) + (v / 32)) % 2 == 1) begin r = 3; g = 3; b = 3; end
                default: ;
            endcase
        end
        hl = pol ? int'(hs) : int'(!hs);
        vl = pol ? int'(vs) : int'(!vs);
        return 8'((r / 2) * 128 + (g / 2) * 64 + (b / 2) * 32 + vl * 16 +
                  (r % 2) * 8 + (g % 2) * 4 + (b % 2) * 2 + hl);
    endfunction

    task automatic gen_pixel();
        int h, v, f;
        logic [5:0] ca;
        logic [2:0] cb;
        h = n % HT;
        v = (n / HT) % VT;
        f = n / (HT * VT);
        if (h == 0 && v == 0) begin
            mode_in = sparse ? 2'd0 : 2'(f % 4);
            frame_mode = mode_in;
        end else if (h == 0 && v == VA / 2) begin
            mode_in = 2'($urandom_range(0, 3));
        end
        ca = sparse ? ((h == 5) ? 6'h3f : 6'h00) : 6'($urandom);
        cb = sparse ? 3'b101 : 3'($urandom);
        pixq.push_back({10'(h), 10'(v), (h < HA) && (v < VA), (h == 0) && (v == 0), h == 0});
        outq_a.push_back(model_uo(h, v, frame_mode, int'(ca), 2, 1'b0));
        outq_b.push_back(model_uo(h, v, frame_mode, int'(cb), 1, 1'b1));
        hist_a.push_back(ca);
        rgb_a = (hist_a.size() > LA) ? hist_a.pop_front() : 6'($urandom);
        rgb_b = cb;
        n++;
    endtask

    task automatic do_reset(int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        pixq.delete(); outq_a.delete(); outq_b.delete(); hist_a.delete();
        repeat (cycles) begin
            @(negedge clk);
            pixq.push_back({10'd0, 10'd0, 3'b111});
            outq_a.push_back(8'h11);
            outq_b.push_back(8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (LA + 1) outq_a.push_back(8'h11);
        repeat (LB + 1) outq_b.push_back(8'h00);
        gen_pixel();
    endtask

    task automatic check(string name, logic [22:0] act, logic [22:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s n=%0d got %h expected %h", name, n, act, exp);
        end
    endtask

    initial begin
        logic [22:0] ep;
        logic [7:0]  eo;
        forever begin
            @(negedge clk);
            #2;
            if (pixq.size() > 0) begin
                ep = pixq.pop_front();
                check("decode_a", {px_a, py_a, pv_a, fs_a, ls_a}, ep);
                check("decode_b", {px_b, py_b, pv_b, fs_b, ls_b}, ep);
            end
            if (outq_a.size() > 0) begin
                eo = outq_a.pop_front();
                check("uo_out_a", {15'd0, uo_a}, {15'd0, eo});
            end
            if (outq_b.size() > 0) begin
                eo = outq_b.pop_front();
                check("uo_out_b", {15'd0, uo_b}, {15'd0, eo});
            end
        end
    end

    initial begin
        do_reset(3);
        repeat (5 * HT * VT - 1) begin
            @(negedge clk);
            gen_pixel();
        end
        while (!((n % HT) == 30 && ((n / HT) % VT) == 20)) begin
            @(negedge clk);
            gen_pixel();
        end
        sparse = 1'b1;
        do_reset(2);
        repeat (HT * VT + 20) begin
            @(negedge clk);
            gen_pixel();
        end
        @(negedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vga_pmod_driver.md
VGA_PMOD_DRIVER -- requirements
Module: vga_pmod_driver

Interface
REQ-001 Parameter COLOR_W, default 2: bits per colour channel on rgb_in, legal 1..4.
REQ-002 Parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48: horizontal timing in clocks.
REQ-003 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical timing in lines.
REQ-004 Parameter SYNC_POL, default 0: sync polarity; 0 = active-low, 1 = active-high.
REQ-005 Parameter LATENCY, default 1: renderer pipeline depth in clocks, legal 0..7.
REQ-006 clk  input  1  pixel clock, single clock domain.
REQ-007 rst_n  input  1  synchronous, active-low reset.
REQ-008 mode_in  input  2  display mode request: 0 scene, 1 colour bars, 2 checkerboard, 3 black.
REQ-009 rgb_in  input  3*COLOR_W  renderer pixel {R,G,B}, MSB-first, valid LATENCY clocks after the matching pix_x/pix_y.
REQ-010 pix_x  output  10  current horizontal counter.
REQ-011 pix_y  output  10  current vertical counter.
REQ-012 pix_valid  output  1  high when pix_x < H_ACTIVE and pix_y < V_ACTIVE.
REQ-013 frame_start  output  1  one-clock pulse when pix_x = 0 and pix_y = 0.
REQ-014 line_start  output  1  one-clock pulse when pix_x = 0, on every line.
REQ-015 uo_out  output  8  TinyVGA PMOD: {R1,G1,B1,VSYNC,R0,G0,B0,HSYNC}.

Function
REQ-016 The horizontal counter shall count 0..H_TOTAL-1 (H_TOTAL = sum of horizontal parameters) and wrap to 0.
REQ-017 The vertical counter shall increment when the horizontal counter wraps, count 0..V_TOTAL-1, and wrap to 0.
REQ-018 pix_x, pix_y, pix_valid, frame_start and line_start shall be combinational decodes of the counters.
REQ-019 hsync shall be active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync likewise on v; output level per SYNC_POL.
REQ-020 hsync, vsync, pix_valid and the internal pattern colour shall be delayed LATENCY clocks so they align with rgb_in.
REQ-021 uo_out shall be registered; total latency from counter value to uo_out shall be LATENCY+1 clocks.
REQ-022 Colour reduction: each channel uses its top 2 bits; with COLOR_W = 1, that bit is replicated to both PMOD bits.
REQ-023 When delayed pix_valid is low, all six colour bits shall be 0, regardless of mode.
REQ-024 mode_in shall be sampled into the active-mode register only on the frame_start clock; mid-frame changes have no effect until the next frame.
REQ-025 Mode 1: bar = pix_x*8/H_ACTIVE (0..7); R = {2{bar[2]}}, G = {2{bar[1]}}, B = {2{bar[0]}}.
REQ-026 Mode 2: all channels 2'b11 when pix_x[5]^pix_y[5] = 1, else 0.
REQ-027 Mode 3: all colour bits 0; sync continues normally.
REQ-028 Mode switches shall take effect atomically at the first output pixel of a frame, with no partially switched pixel.

Reset
REQ-029 While rst_n is low at a clk edge, counters, active mode and the delay line shall clear (delayed pix_valid = 0, delayed syncs = inactive).
REQ-030 After reset, uo_out shall show inactive syncs and zero colour (8'h11 for SYNC_POL = 0, 8'h00 for SYNC_POL = 1).
REQ-031 A reset mid-frame shall restart timing at h = 0, v = 0, with frame_start asserted on the first clock after rst_n rises.

Configuration
REQ-032 Macro VGA_PMOD_TESTPAT_EN shall enable the mode 1 and mode 2 pattern generators.
REQ-033 When VGA_PMOD_TESTPAT_EN is undefined, modes 1 and 2 shall behave as mode 0, and no pattern logic shall be synthesised.

Verification
REQ-034 Defaults, free-run one frame -> hsync period 800 clocks, low 96 clocks, vsync low 2 lines, frame length 420000 clocks.
REQ-035 LATENCY = 3, mode 0, rgb_in = 6'b111111 only when pix_x = 5 (3-clock-delayed model) -> uo_out colour bits all 1 for exactly one clock, 4 clocks after pix_x = 5.
REQ-036 Mode 1 with TESTPAT -> at visible x = 0, 80, 160 the colour bits are {R,G,B} = 000, 001, 010 (each channel 2'b11 when set).
REQ-037 mode_in changes 0 -> 3 at pix_y = 100 -> current frame still scene; next frame all colour bits 0 from first pixel; sync unaffected.
REQ-038 rst_n low for 2 clocks at h = 300, v = 200 -> uo_out = 8'h11 next clock; frame_start on first clock after release.
REQ-039 COLOR_W = 1, SYNC_POL = 1, rgb_in = 3'b101 during active video -> colour bits R = 11, G = 00, B = 11; blanking shows uo_out = 8'h00 outside sync.
